// File: rtl/ball_paddle_render.sv
// Single-player ball and paddle game renderer driven by an external VGA sync generator.
// Game state advances once per frame; pixel colour and sync leave through a one-clock register stage.
module ball_paddle_render #(
    parameter int unsigned BALL_SIZE = 8,
    parameter int unsigned PAD_W     = 64,
    parameter int unsigned PAD_H     = 8,
    parameter int unsigned PAD_Y     = 464,
    parameter int unsigned BALL_SPD  = 2,
    parameter int unsigned PAD_SPD   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] Hcnt,
    input  logic [9:0] Vcnt,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic       btn_l,
    input  logic       btn_r,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue,
    output logic       hs,
    output logic       vs,
    output logic [7:0] score,
    output logic       game_over
);

    // Positions are kept 11 bits wide so no sum or compare can wrap past 1023.
    localparam int unsigned W = 11;
    localparam logic [W-1:0] H_VIS   = W'(640);
    localparam logic [W-1:0] V_VIS   = W'(480);
    localparam logic [W-1:0] BS      = W'(BALL_SIZE);
    localparam logic [W-1:0] PW      = W'(PAD_W);
    localparam logic [W-1:0] PH      = W'(PAD_H);
    localparam logic [W-1:0] PY      = W'(PAD_Y);
    localparam logic [W-1:0] BSPD    = W'(BALL_SPD);
    localparam logic [W-1:0] PSPD    = W'(PAD_SPD);
    localparam logic [W-1:0] SERVE_X = W'(316);
    localparam logic [W-1:0] SERVE_Y = W'(100);
    localparam logic [W-1:0] PAD_X0  = W'(288);

    typedef enum logic [1:0] {SERVE, PLAY, OVER} state_t;

    state_t         state, state_d;
    logic [W-1:0]   bx, by, px, bx_d, by_d, px_d;
    logic           dx, dy, dx_d, dy_d;     // 1 = moving right / down
    logic [7:0]     score_d;
    logic [W-1:0]   h, v;
    logic           frame_tick, hit, in_ball, in_pad, visible;
    logic [11:0]    rgb_c;

    assign h          = {1'b0, Hcnt};
    assign v          = {1'b0, Vcnt};
    assign frame_tick = (Hcnt == 10'd0) && (Vcnt == 10'd480);

    // Ball meets the paddle top this frame while descending with horizontal overlap.
    assign hit = dy && (by + BS <= PY) && (by + BS + BSPD >= PY)
                 && (bx + BS > px) && (bx < px + PW);

    // Next-state and next-position logic; only frame_tick changes anything.
    always_comb begin
        state_d = state;
        bx_d    = bx;
        by_d    = by;
        dx_d    = dx;
        dy_d    = dy;
        px_d    = px;
        score_d = score;
        if (frame_tick) begin
            if (state != OVER) begin
                if (btn_l && !btn_r)
                    px_d = (px >= PSPD) ? px - PSPD : '0;
                else if (btn_r && !btn_l)
                    px_d = (px + PSPD > H_VIS - PW) ? H_VIS - PW : px + PSPD;
            end
            case (state)
                SERVE: begin
                    if (btn_l || btn_r)
                        state_d = PLAY;
                end
                PLAY: begin
                    if (dx) begin
                        if (bx + BS + BSPD >= H_VIS) begin
                            bx_d = H_VIS - BS;
                            dx_d = 1'b0;
                        end else begin
                            bx_d = bx + BSPD;
                        end
                    end else begin
                        if (bx <= BSPD) begin
                            bx_d = '0;
                            dx_d = 1'b1;
                        end else begin
                            bx_d = bx - BSPD;
                        end
                    end
                    if (!dy) begin
                        if (by <= BSPD) begin
                            by_d = '0;
                            dy_d = 1'b1;
                        end else begin
                            by_d = by - BSPD;
                        end
                    end else if (hit) begin
                        by_d    = PY - BS;
                        dy_d    = 1'b0;
                        score_d = (score == 8'hFF) ? score : score + 8'd1;
                    end else if (by + BSPD >= V_VIS - BS) begin
                        by_d    = V_VIS - BS;
                        state_d = OVER;
                    end else begin
                        by_d = by + BSPD;
                    end
                end
                OVER: begin
                    if (btn_l || btn_r) begin
                        state_d = SERVE;
                        score_d = 8'd0;
                        bx_d    = SERVE_X;
                        by_d    = SERVE_Y;
                        dx_d    = 1'b1;
                        dy_d    = 1'b1;
                    end
                end
                default: state_d = SERVE;
            endcase
        end
    end

    // Game state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SERVE;
            bx        <= SERVE_X;
            by        <= SERVE_Y;
            dx        <= 1'b1;
            dy        <= 1'b1;
            px        <= PAD_X0;
            score     <= 8'd0;
            game_over <= 1'b0;
        end else begin
            state     <= state_d;
            bx        <= bx_d;
            by        <= by_d;
            dx        <= dx_d;
            dy        <= dy_d;
            px        <= px_d;
            score     <= score_d;
            game_over <= (state_d == OVER);
        end
    end

    // Pixel colour for the current counter position: ball over paddle over background.
    always_comb begin
        visible = (h < H_VIS) && (v < V_VIS);
        in_ball = (h >= bx) && (h < bx + BS) && (v >= by) && (v < by + BS);
        in_pad  = (h >= px) && (h < px + PW) && (v >= PY) && (v < PY + PH);
        rgb_c   = 12'h000;
        if (visible) begin
            if (in_ball)
                rgb_c = 12'hFFF;
            else if (in_pad)
                rgb_c = 12'h0F0;
            else if (state == OVER)
                rgb_c = 12'h400;
            else
                rgb_c = 12'h002;
        end
    end

    // Output stage keeps colour and sync aligned with one clock of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red   <= 4'h0;
            green <= 4'h0;
            blue  <= 4'h0;
            hs    <= 1'b1;
            vs    <= 1'b1;
        end else begin
            red   <= rgb_c[11:8];
            green <= rgb_c[7:4];
            blue  <= rgb_c[3:0];
            hs    <= hs_in;
            vs    <= vs_in;
        end
    end

endmodule

// File: tb/tb_ball_paddle_render.sv
// Directed bench: frame ticks are single-cycle (0,480) counter values, positions are probed via pixels.
module tb_ball_paddle_render;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] Hcnt, Vcnt;
    logic       hs_in, vs_in, btn_l, btn_r;
    logic [3:0] red, green, blue;
    logic       hs, vs;
    logic [7:0] score;
    logic       game_over;

    int errors = 0;
    int checks = 0;
    int k = 0;
    logic hsv = 1'b0;

    localparam logic [11:0] C_BALL = 12'hFFF;
    localparam logic [11:0] C_PAD  = 12'h0F0;
    localparam logic [11:0] C_BG   = 12'h002;
    localparam logic [11:0] C_OVER = 12'h400;
    localparam logic [11:0] C_BLK  = 12'h000;

    ball_paddle_render dut (
        .clk(clk), .rst(rst), .Hcnt(Hcnt), .Vcnt(Vcnt),
        .hs_in(hs_in), .vs_in(vs_in), .btn_l(btn_l), .btn_r(btn_r),
        .red(red), .green(green), .blue(blue), .hs(hs), .vs(vs),
        .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One frame tick with the given buttons held across it.
    task automatic tick(input logic l, input logic r);
        @(negedge clk);
        Hcnt = 10'd0; Vcnt = 10'd480; btn_l = l; btn_r = r;
        @(negedge clk);
        Hcnt = 10'd700; Vcnt = 10'd500; btn_l = 1'b0; btn_r = 1'b0;
    endtask

    // Advance to PLAY tick number target.
    task automatic run_to(input int target, input logic l, input logic r);
        while (k < target) begin
            tick(l, r);
            k++;
        end
    endtask

    // Drive one pixel position and check colour plus sync one clock later.
    task automatic pix(input string tag, input int x, input int y, input logic [11:0] exp);
        @(negedge clk);
        Hcnt = 10'(x); Vcnt = 10'(y);
        hsv = ~hsv; hs_in = hsv; vs_in = ~hsv;
        @(negedge clk);
        chk(tag, {4'h0, red, green, blue}, {4'h0, exp});
        chk({tag, "_hs"}, {15'h0, hs}, {15'h0, hsv});
        chk({tag, "_vs"}, {15'h0, vs}, {15'h0, ~hsv});
        Hcnt = 10'd700; Vcnt = 10'd500;
    endtask

    initial begin
        rst = 1'b1; Hcnt = 10'd320; Vcnt = 10'd104;
        hs_in = 1'b0; vs_in = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rgb", {4'h0, red, green, blue}, 16'h0000);
        chk("rst_hs", {15'h0, hs}, 16'h1);
        chk("rst_vs", {15'h0, vs}, 16'h1);
        chk("rst_score", {8'h0, score}, 16'h0);
        chk("rst_go", {15'h0, game_over}, 16'h0);

        // Serve: ball held, paddle centred.
        rst = 1'b0;
        Hcnt = 10'd700; Vcnt = 10'd500;
        tick(0, 0); tick(0, 0); tick(0, 0);
        pix("serve_ball_c", 320, 104, C_BALL);
        pix("serve_ball_tl", 316, 100, C_BALL);
        pix("serve_ball_l", 315, 100, C_BG);
        pix("serve_ball_t", 316, 99, C_BG);
        pix("serve_ball_br", 323, 107, C_BALL);
        pix("serve_ball_r", 324, 107, C_BG);
        pix("serve_pad_l", 288, 464, C_PAD);
        pix("serve_pad_l1", 287, 464, C_BG);
        pix("serve_pad_br", 351, 471, C_PAD);
        pix("serve_pad_r1", 352, 464, C_BG);
        pix("serve_pad_b1", 288, 472, C_BG);
        chk("serve_score", {8'h0, score}, 16'h0);

        // Serve with btn_r: paddle steps, ball stays this tick.
        tick(0, 1);
        pix("play_pad_292", 292, 464, C_PAD);
        pix("play_pad_291", 291, 464, C_BG);
        pix("play_ball0", 316, 100, C_BALL);
        run_to(1, 0, 0);
        pix("k1_ball", 318, 102, C_BALL);
        pix("k1_ball_l", 317, 102, C_BG);
        pix("k1_ball_t", 318, 101, C_BG);

        // Hold right until the paddle clamps at 576.
        run_to(80, 0, 1);
        pix("pad_clamp_r", 576, 464, C_PAD);
        pix("pad_clamp_r1", 575, 464, C_BG);
        pix("pad_clamp_br", 639, 471, C_PAD);
        pix("k80_ball", 476, 260, C_BALL);

        // Right wall reflection.
        run_to(157, 0, 0);
        pix("k157_ball", 630, 414, C_BALL);
        pix("k157_ball_l", 629, 414, C_BG);
        run_to(158, 0, 0);
        pix("wall_r_ball", 632, 416, C_BALL);
        pix("wall_r_l", 631, 416, C_BG);
        pix("wall_r_edge", 639, 423, C_BALL);
        run_to(159, 0, 0);
        pix("wall_r_back", 630, 418, C_BALL);
        pix("wall_r_back_r", 638, 418, C_BG);

        // Paddle hit.
        run_to(177, 0, 0);
        pix("k177_ball", 594, 454, C_BALL);
        chk("k177_score", {8'h0, score}, 16'h0);
        run_to(178, 0, 0);
        chk("hit_score", {8'h0, score}, 16'h1);
        pix("hit_ball", 592, 456, C_BALL);
        pix("hit_ball_t", 592, 455, C_BG);
        run_to(179, 0, 0);
        pix("hit_up", 590, 454, C_BALL);
        pix("hit_up_b", 590, 462, C_BG);

        // Hold left until the paddle clamps at 0, then both buttons.
        run_to(350, 1, 0);
        pix("pad_clamp_l", 0, 464, C_PAD);
        pix("pad_clamp_l63", 63, 471, C_PAD);
        pix("pad_clamp_l64", 64, 464, C_BG);
        run_to(355, 1, 1);
        pix("pad_both_0", 0, 464, C_PAD);
        pix("pad_both_64", 64, 464, C_BG);

        // Top wall, then left wall.
        run_to(406, 0, 0);
        pix("wall_top", 136, 0, C_BALL);
        run_to(474, 0, 0);
        pix("wall_left", 0, 136, C_BALL);
        run_to(475, 0, 0);
        pix("wall_left_l", 1, 138, C_BG);
        pix("wall_left_b", 2, 138, C_BALL);

        // Miss the paddle and fall out.
        run_to(633, 0, 0);
        pix("k633_ball", 318, 454, C_BALL);
        run_to(641, 0, 0);
        chk("k641_go", {15'h0, game_over}, 16'h0);
        pix("k641_ball", 334, 470, C_BALL);
        run_to(642, 0, 0);
        chk("over_go", {15'h0, game_over}, 16'h1);
        chk("over_score", {8'h0, score}, 16'h1);
        pix("over_bg", 10, 10, C_OVER);
        pix("over_pad", 0, 464, C_PAD);
        tick(0, 0);
        chk("over_hold", {15'h0, game_over}, 16'h1);

        // Re-serve from OVER.
        tick(1, 0);
        chk("reserve_go", {15'h0, game_over}, 16'h0);
        chk("reserve_score", {8'h0, score}, 16'h0);
        pix("reserve_ball", 316, 100, C_BALL);
        pix("reserve_bg", 10, 10, C_BG);
        pix("reserve_pad", 0, 464, C_PAD);
        pix("blank_h", 700, 10, C_BLK);
        pix("blank_v", 10, 490, C_BLK);

        // Reset mid-line while in PLAY.
        tick(0, 1);
        tick(0, 0);
        @(negedge clk);
        Hcnt = 10'd318; Vcnt = 10'd102; hs_in = 1'b0; vs_in = 1'b0;
        @(posedge clk);
        #2;
        chk("pre_rst_rgb", {4'h0, red, green, blue}, {4'h0, C_BALL});
        chk("pre_rst_hs", {15'h0, hs}, 16'h0);
        #1 rst = 1'b1;
        #1;
        chk("async_rgb", {4'h0, red, green, blue}, 16'h0000);
        chk("async_hs", {15'h0, hs}, 16'h1);
        chk("async_vs", {15'h0, vs}, 16'h1);
        @(negedge clk);
        rst = 1'b0;
        pix("post_rst_ball", 316, 100, C_BALL);
        pix("post_rst_pad", 288, 464, C_PAD);
        pix("post_rst_pad_old", 4, 464, C_BG);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
